// File: rtl/common.sv
// Shared writeback-stage types: pipeline register layouts, trap record, commit record,
// stage FSM encoding and the destination-register decode helper.
package common;

    typedef logic [63:0] word_t;

    localparam int TRAP_CODE_W = 6;

    typedef enum logic [2:0] {
        OP_NONE,
        OP_ALU,
        OP_LOAD,
        OP_STORE,
        OP_BRANCH,
        OP_JUMP,
        OP_CSR,
        OP_SYSTEM
    } op_e;

    typedef struct packed {
        logic                   trap_valid;
        logic                   is_exception;
        logic [TRAP_CODE_W-1:0] code;
    } trap_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] inst;
        word_t       inst_pc;
        op_e         op;
        word_t       value;
        trap_t       trap;
        logic [11:0] csr;
        word_t       inst_counter;
        logic        difftest_skip;
    } mem_wb;

    typedef struct packed {
        logic       reg_write_enable;
        logic [4:0] reg_dest_addr;
        word_t      reg_write_data;
    } reg_writer;

    typedef struct packed {
        logic        valid;
        word_t       pc;
        logic [31:0] inst;
        logic        wen;
        logic [4:0]  wdest;
        word_t       wdata;
        logic        skip;
    } commit_t;

    typedef enum logic {
        RUN,
        REDIRECT
    } wb_state_e;

    function automatic logic is_write_reg(input op_e op);
        return (op == OP_ALU) || (op == OP_LOAD) || (op == OP_JUMP) || (op == OP_CSR);
    endfunction

endpackage

// File: rtl/trap_redirect.sv
// RUN/REDIRECT control for the writeback stage: latches a trapping instruction's
// cause and PC and holds the redirect request until the consumer acknowledges it.
module trap_redirect
    import common::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   fire,
    input  trap_t                  trap,
    input  word_t                  trap_pc,
    input  logic                   ack,
    output logic                   redirect_valid,
    output logic [TRAP_CODE_W-1:0] redirect_code,
    output word_t                  redirect_pc,
    output logic                   redirect_exc,
    output logic                   ok
);

    wb_state_e state;
    wb_state_e state_next;
    logic      take_trap;

    assign take_trap = fire && trap.trap_valid && (state == RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // An ack seen in RUN has nothing to release, so it is simply dropped.
    always_comb begin
        state_next = state;
        case (state)
            RUN:      if (take_trap) state_next = REDIRECT;
            REDIRECT: if (ack) state_next = RUN;
            default:  state_next = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            redirect_code <= '0;
            redirect_pc   <= '0;
            redirect_exc  <= 1'b0;
        end else if (take_trap) begin
            redirect_code <= trap.code;
            redirect_pc   <= trap_pc;
            redirect_exc  <= trap.is_exception;
        end
    end

    assign redirect_valid = (state == REDIRECT);
    assign ok             = (state == RUN);

endmodule

// File: rtl/writeback.sv
// Writeback stage: retires each mem_wb instruction once, drives the register-file
// write/forward port, counts retirements and raises trap redirects.
// Optional macro WB_DIFFTEST_EN builds the registered difftest commit record.
module writeback
    import common::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  mem_wb                  mem_wb_state,
    output reg_writer              rf_write,
    output logic                   redirect_valid,
    output logic [TRAP_CODE_W-1:0] redirect_code,
    output word_t                  redirect_pc,
    output logic                   redirect_exc,
    input  logic                   redirect_ack,
    output logic [63:0]            instret,
    output commit_t                commit,
    output logic                   ok
);

    word_t       last_counter;
    logic [63:0] retired;
    logic        fire;
    logic        wen;
    logic [4:0]  rd;
    logic        unused_bits;

    assign rd = mem_wb_state.inst[11:7];

    // A counter equal to the last retired one is a stalled duplicate of that instruction.
    assign fire = !rst && enable && mem_wb_state.valid && ok &&
                  (mem_wb_state.inst_counter != last_counter);

    assign wen = fire && is_write_reg(mem_wb_state.op) &&
                 !mem_wb_state.trap.trap_valid && (rd != 5'd0);

    always_comb begin
        rf_write                  = '0;
        rf_write.reg_write_enable = wen;
        if (wen) begin
            rf_write.reg_dest_addr  = rd;
            rf_write.reg_write_data = mem_wb_state.value;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_counter <= '1;
            retired      <= '0;
        end else if (fire) begin
            last_counter <= mem_wb_state.inst_counter;
            if (!mem_wb_state.trap.trap_valid) retired <= retired + 64'd1;
        end
    end

    assign instret = retired;

    trap_redirect u_trap_redirect (
        .clk            (clk),
        .rst            (rst),
        .fire           (fire),
        .trap           (mem_wb_state.trap),
        .trap_pc        (mem_wb_state.inst_pc),
        .ack            (redirect_ack),
        .redirect_valid (redirect_valid),
        .redirect_code  (redirect_code),
        .redirect_pc    (redirect_pc),
        .redirect_exc   (redirect_exc),
        .ok             (ok)
    );

`ifdef WB_DIFFTEST_EN
    commit_t commit_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            commit_q <= '0;
        end else if (fire) begin
            commit_q.valid <= 1'b1;
            commit_q.pc    <= mem_wb_state.inst_pc;
            commit_q.inst  <= mem_wb_state.inst;
            commit_q.wen   <= wen;
            commit_q.wdest <= rf_write.reg_dest_addr;
            commit_q.wdata <= rf_write.reg_write_data;
            commit_q.skip  <= mem_wb_state.difftest_skip;
        end else begin
            commit_q <= '0;
        end
    end

    assign commit = commit_q;
`else
    assign commit = '0;
`endif

    assign unused_bits = ^{mem_wb_state.csr, mem_wb_state.difftest_skip,
                           mem_wb_state.inst[31:12], mem_wb_state.inst[6:0]};

endmodule
